uart_cmd_rx: RTL
================

// Module: uart_cmd_rx
// PURPOSE
//  UART receiver that takes the BLE command byte stream (8N1, LSB first, idle high) into the Segway.
//  Mirror of the bench-side uart_tx: the byte that uart_tx sends appears on rx_data with rdy set.
//  Feeds the auth/command block ('g' = go, 's' = stop) through an rdy/clr_rdy handshake.
//  Reports framing and overrun errors.
// PARAMETERS
//  BAUD_DIV   2604  clk cycles per bit (50 MHz / 19200 baud); must be >= 8
//  DATA_BITS  8     payload bits per frame
// PORTS
//  clk      in   1          system clock; all logic runs on its rising edge
//  rst      in   1          asynchronous active-high reset
//  RX       in   1          serial input, asynchronous to clk, idle high
//  clr_rdy  in   1          consumer ack; clears rdy, ovr_err and frm_err
//  rx_data  out  DATA_BITS  last good byte received
//  rdy      out  1          a byte is available; stays high until clr_rdy
//  frm_err  out  1          sticky: stop bit was sampled low
//  ovr_err  out  1          sticky: a good byte completed while rdy was still 1
// BEHAVIOUR
//  Reset (async, rst=1): synchroniser flops = 1, state = IDLE, counters = 0, rx_data = 0,
//   rdy = 0, frm_err = 0, ovr_err = 0.
//  RX passes through two flops (preset to 1); a third flop gives falling-edge detection.
//  Bit counter is DATA_BITS+2 wide in range. Baud counter is $clog2(BAUD_DIV) bits and counts down.
//  State machine:
//   IDLE:  a falling edge on synced RX loads baud_cnt = BAUD_DIV/2 - 1 and moves to START.
//   START: when baud_cnt = 0, sample RX. If RX = 0, load BAUD_DIV-1, clear bit_cnt, go to DATA.
//          If RX = 1 (glitch or false start), return to IDLE with no flag change.
//   DATA:  at each baud_cnt = 0, shift the sample into shreg MSB-first, so the first bit ends at the LSB.
//          Reload BAUD_DIV-1. After DATA_BITS samples, go to STOP.
//   STOP:  at baud_cnt = 0, sample RX.
//          If RX = 1: rx_data <= shreg, rdy <= 1, frm_err <= 0.
//          If RX = 0: frm_err <= 1; rx_data and rdy are unchanged.
//          Either way, return to IDLE in the same cycle.
//  Each sample is taken at the centre of its bit.
//  Latency: rdy rises 2 + BAUD_DIV/2 + (DATA_BITS+1)*BAUD_DIV cycles (±1) after the RX falling edge.
//  Overrun: if a good stop occurs while rdy = 1 and clr_rdy = 0, set ovr_err and overwrite rx_data.
//   rdy stays 1.
//  Simultaneous clr_rdy and a good stop: completion wins. rdy = 1 next cycle, ovr_err is not set,
//   frm_err is cleared.
//  clr_rdy while idle or mid-frame: clears the flags only and never disturbs the reception in progress.
//  Back-to-back frames: return to IDLE at mid-stop-bit, so the next start edge is detected
//   with no dead time.
//  RX held low indefinitely (break): START passes, the frame ends with frm_err = 1, and the FSM
//   waits in IDLE for a fresh falling edge. There is no repeated error.
//  rst mid-frame: immediate abort to the reset values; the partial byte is discarded.
// STRUCTURE
//  uart_pkg: typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
//   localparam BAUD_DIV_19200 = 2604 (shared with uart_tx).
//  Sub-module rx_synch: two-flop synchroniser with async preset to 1, plus edge-detect flop.
//   Its outputs are rx_s and rx_fall.
//  The FSM, counters, shift register and flags stay in uart_cmd_rx.
// TESTING
//  Loopback from bench uart_tx (same BAUD_DIV):
//  1. Send 0x67 -> rdy=1, rx_data=8'h67, frm_err=0, ovr_err=0; rdy clears the cycle after clr_rdy.
//  2. Send 0x67 then 0x73 with no clr_rdy -> rx_data=8'h73, rdy=1, ovr_err=1;
//     clr_rdy -> all flags 0.
//  3. Drive RX low for 1000 cycles (< BAUD_DIV/2), then high -> FSM back to IDLE, rdy=0,
//     no flags set.
//  4. Send a frame with the stop bit forced 0 (data 0xA5) -> frm_err=1, rdy=0,
//     rx_data keeps its previous value.
//  5. Pulse clr_rdy on the exact cycle a good stop is sampled (0x3C) -> rdy=1, rx_data=8'h3C,
//     ovr_err=0.
//  6. Assert rst during bit 4 of 0xFF, release it, then send 0x55 -> rx_data=8'h55, rdy=1,
//     no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the standard baud divisor.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  // 50 MHz / 19200 baud; uart_tx uses the same value.
  localparam int BAUD_DIV_19200 = 2604;

endpackage

// File: rtl/uart_cmd_rx_synch.sv
// RX metastability synchroniser (two flops, preset high) plus a falling-edge detect flop.
module rx_synch (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic ff1, ff2, ff3;

  // Preset to 1 so a reset line reads as idle and never fakes a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1 <= 1'b1;
      ff2 <= 1'b1;
      ff3 <= 1'b1;
    end else begin
      ff1 <= rx;
      ff2 <= ff1;
      ff3 <= ff2;
    end
  end

  assign rx_s    = ff2;
  assign rx_fall = ff3 & ~ff2;

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver for the BLE command stream, with rdy/clr_rdy handshake and sticky errors.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = BAUD_DIV_19200,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frm_err,
  output logic                 ovr_err
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(DATA_BITS + 2);

  localparam logic [BW-1:0] BAUD_LD  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LD  = BW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  rx_state_t            state;
  logic [BW-1:0]        baud_cnt;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s, rx_fall;
  logic                 tick, stop_good, stop_bad;

  rx_synch u_synch (
    .clk     (clk),
    .rst     (rst),
    .rx      (RX),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  // Sample strobe: baud counter expired, so we are at the centre of a bit.
  assign tick      = (baud_cnt == '0);
  assign stop_good = (state == STOP) && tick &&  rx_s;
  assign stop_bad  = (state == STOP) && tick && !rx_s;

  // Frame sequencing: start-edge qualify, data shift, stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_fall) begin
            baud_cnt <= HALF_LD;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            // A high line at mid-start-bit is a glitch; drop back silently.
            if (!rx_s) begin
              baud_cnt <= BAUD_LD;
              bit_cnt  <= '0;
              state    <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            // LSB arrives first, so shifting in from the top leaves it at bit 0.
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt  <= bit_cnt + CW'(1);
            baud_cnt <= BAUD_LD;
            if (bit_cnt == LAST_BIT) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
          if (tick) state <= IDLE;
          else      baud_cnt <= baud_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output byte and flags; a completing frame overrides a same-cycle clr_rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      if (clr_rdy) begin
        rdy     <= 1'b0;
        frm_err <= 1'b0;
        ovr_err <= 1'b0;
      end
      if (stop_good) begin
        rx_data <= shreg;
        rdy     <= 1'b1;
        frm_err <= 1'b0;
        if (rdy && !clr_rdy) ovr_err <= 1'b1;
      end else if (stop_bad) begin
        frm_err <= 1'b1;
      end
    end
  end

endmodule
